// File: rtl/imm_pkg.sv
// Shared types and constants for the buffered immediate extender.
// Decoded entries are built at IMM_MAX_W / TAG_MAX_W and truncated by the top
// level to its DATA_W / TAG_W parameters.
// The top level therefore supports DATA_W <= 64 and TAG_W <= 16.
package imm_pkg;

  localparam int IMM_MAX_W = 64;
  localparam int TAG_MAX_W = 16;
  localparam int BR_SHIFT  = 2;

  typedef enum logic [2:0] {
    IMM8   = 3'd0,
    IMM12  = 3'd1,
    BR24   = 3'd2,
    SPLIT8 = 3'd3,
    ROT8   = 3'd4,
    IMM24  = 3'd5,
    RSV6   = 3'd6,
    RSV7   = 3'd7
  } imm_src_e;

  typedef struct packed {
    logic [IMM_MAX_W-1:0] ExtImm;
    logic [TAG_MAX_W-1:0] tag;
    logic                 err;
    logic                 rot_c;
  } imm_entry_t;

  // Rotate a 32-bit word right by amt bits.
  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
    logic [63:0] dbl;
    dbl = {v, v} >> amt;
    return dbl[31:0];
  endfunction

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate decode: turns one instruction field and mode into
// a full-width extended immediate with its error and rotate-carry flags.
// Macro ROTATE_IMM_EN enables the ARM rotated-immediate mode (ROT8); without
// it ROT8 is reported as an undefined mode.
module imm_extend_core
  import imm_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic [23:0]      instr_i,
  input  logic [2:0]       imm_src_i,
  input  logic [TAG_W-1:0] tag_i,
  output imm_entry_t       ent_o
);

  localparam int BR_W = 24 + BR_SHIFT;

  imm_src_e        src;
  logic [BR_W-1:0] br_off;

  assign src    = imm_src_e'(imm_src_i);
  assign br_off = {instr_i, {BR_SHIFT{1'b0}}};

`ifdef ROTATE_IMM_EN
  logic [4:0]  rot;
  logic [31:0] val32;

  assign rot   = {instr_i[11:8], 1'b0};
  assign val32 = ror32({24'd0, instr_i[7:0]}, rot);
`endif

  // Mode decode; undefined modes yield a zero immediate with err set.
  always_comb begin
    ent_o     = '0;
    ent_o.tag = TAG_MAX_W'(tag_i);
    case (src)
      IMM8:   ent_o.ExtImm = IMM_MAX_W'(instr_i[7:0]);
      IMM12:  ent_o.ExtImm = IMM_MAX_W'(instr_i[11:0]);
      BR24:   ent_o.ExtImm = {{(IMM_MAX_W-BR_W){br_off[BR_W-1]}}, br_off};
      SPLIT8: ent_o.ExtImm = IMM_MAX_W'({instr_i[11:8], instr_i[3:0]});
      ROT8: begin
`ifdef ROTATE_IMM_EN
        ent_o.ExtImm = IMM_MAX_W'(val32);
        ent_o.rot_c  = (rot != 5'd0) & val32[31];
`else
        ent_o.err    = 1'b1;
`endif
      end
      IMM24:  ent_o.ExtImm = IMM_MAX_W'(instr_i);
      default: ent_o.err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Buffered immediate extender: decodes at the input, stores results in a
// DEPTH-entry FIFO and presents them in order over valid/ready.
// Optional macro ROTATE_IMM_EN enables the rotated-immediate mode in the core.
// DATA_W must be in 32..64, DEPTH a power of two >= 2, TAG_W <= 16.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [23:0]       Instr,
  input  logic [2:0]        ImmSrc,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ExtImm,
  output logic [TAG_W-1:0]  out_tag,
  output logic              ext_err,
  output logic              rot_c
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  imm_entry_t        core_ent;
  logic              unused_ent;
  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [PTR_W-1:0]  head;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] imm_q [DEPTH];
  logic [TAG_W-1:0]  tag_q [DEPTH];
  logic [DEPTH-1:0]  err_q;
  logic [DEPTH-1:0]  rot_q;

  imm_extend_core #(
    .TAG_W(TAG_W)
  ) u_core (
    .instr_i   (Instr),
    .imm_src_i (ImmSrc),
    .tag_i     (in_tag),
    .ent_o     (core_ent)
  );

  // Only the low DATA_W / TAG_W bits of the decoded entry are stored.
  assign unused_ent = ^core_ent;

  assign in_ready  = (cnt_q != CNT_W'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // While empty, the most recently popped entry still sits one slot behind
  // the read pointer, so the outputs hold their last values.
  assign head    = out_valid ? rd_q : rd_q - PTR_W'(1);
  assign ExtImm  = imm_q[head];
  assign out_tag = tag_q[head];
  assign ext_err = err_q[head];
  assign rot_c   = rot_q[head];

  // Pointer and occupancy next-state; pointers wrap because DEPTH is a power of two.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + PTR_W'(1);
    if (pop)  rd_d = rd_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: ;
    endcase
  end

  // Control registers: pointers and count, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; written only on an accepted push so idle input bits never land here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        imm_q[i] <= '0;
        tag_q[i] <= '0;
      end
      err_q <= '0;
      rot_q <= '0;
    end else if (push) begin
      imm_q[wr_q] <= core_ent.ExtImm[DATA_W-1:0];
      tag_q[wr_q] <= core_ent.tag[TAG_W-1:0];
      err_q[wr_q] <= core_ent.err;
      rot_q[wr_q] <= core_ent.rot_c;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe (DATA_W=32, DEPTH=2, TAG_W=4).
module tb_imm_extend_pipe;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam int TAG_W  = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [23:0]       Instr = '0;
  logic [2:0]        ImmSrc = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] ExtImm;
  logic [TAG_W-1:0]  out_tag;
  logic              ext_err;
  logic              rot_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             err;
    logic             rot;
  } exp_t;

  typedef struct {
    logic [23:0] ins;
    logic [2:0]  src;
    logic [31:0] imm;
    logic        err;
    logic        rot;
  } dvec_t;

  exp_t sb[$];

  imm_extend_pipe #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Instr     (Instr),
    .ImmSrc    (ImmSrc),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ExtImm    (ExtImm),
    .out_tag   (out_tag),
    .ext_err   (ext_err),
    .rot_c     (rot_c)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: the mode table evaluated with plain arithmetic.
  function automatic exp_t model(input logic [23:0] ins, input logic [2:0] src,
                                 input logic [TAG_W-1:0] tg);
    exp_t        e;
    longint      s;
    logic [31:0] v;
    e.imm = '0; e.tag = tg; e.err = 1'b0; e.rot = 1'b0;
    case (src)
      3'd0: e.imm = 32'(ins % 256);
      3'd1: e.imm = 32'(ins % 4096);
      3'd2: begin
        s = longint'($signed(ins)) * 4;
        e.imm = s[31:0];
      end
      3'd3: e.imm = 32'(((ins / 256) % 16) * 16 + (ins % 16));
      3'd4: begin
`ifdef ROTATE_IMM_EN
        v = 32'(ins % 256);
        for (int k = 0; k < 2 * int'(ins[11:8]); k++) v = {v[0], v[31:1]};
        e.imm = v;
        e.rot = (ins[11:8] != 4'd0) ? v[31] : 1'b0;
`else
        e.err = 1'b1;
`endif
      end
      3'd5: e.imm = 32'(ins);
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    Instr = '0; ImmSrc = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (ExtImm !== '0) begin errors++; $display("FAIL reset_ExtImm: got %h want 0", ExtImm); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    checks++; if ({ext_err, rot_c} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {ext_err, rot_c}); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_modes();
    dvec_t v[9];
    v[0] = '{24'hFFFFFE, 3'd2, 32'hFFFFFFF8, 1'b0, 1'b0};
    v[1] = '{24'h000A05, 3'd3, 32'h000000A5, 1'b0, 1'b0};
    v[2] = '{24'h123ABC, 3'd1, 32'h00000ABC, 1'b0, 1'b0};
`ifdef ROTATE_IMM_EN
    v[3] = '{24'h0004FF, 3'd4, 32'hFF000000, 1'b0, 1'b1};
`else
    v[3] = '{24'h0004FF, 3'd4, 32'h00000000, 1'b1, 1'b0};
`endif
    v[4] = '{24'h123456, 3'd0, 32'h00000056, 1'b0, 1'b0};
    v[5] = '{24'hABCDEF, 3'd5, 32'h00ABCDEF, 1'b0, 1'b0};
    v[6] = '{24'h7FFFFF, 3'd2, 32'h01FFFFFC, 1'b0, 1'b0};
    v[7] = '{24'h123456, 3'd6, 32'h00000000, 1'b1, 1'b0};
    v[8] = '{24'hFFFFFF, 3'd7, 32'h00000000, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; Instr = v[i].ins; ImmSrc = v[i].src; in_tag = TAG_W'(i); out_ready = 1'b0;
      @(negedge clk);
      checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL mode%0d_pre: got rdy/vld %b want 10", i, {in_ready, out_valid}); end
      @(posedge clk); #1;
      in_valid = 1'b0; Instr = 'x; ImmSrc = 3'($urandom); out_ready = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mode%0d_latency: got out_valid %b want 1", i, out_valid); end
      checks++;
      if ({ExtImm, out_tag, ext_err, rot_c} !== {v[i].imm, TAG_W'(i), v[i].err, v[i].rot}) begin
        errors++;
        $display("FAIL mode%0d_value: got imm=%h tag=%h err=%b rot=%b want imm=%h tag=%h err=%b rot=%b",
                 i, ExtImm, out_tag, ext_err, rot_c, v[i].imm, TAG_W'(i), v[i].err, v[i].rot);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({out_valid, ExtImm, out_tag, ext_err, rot_c} !== {1'b0, v[i].imm, TAG_W'(i), v[i].err, v[i].rot}) begin
        errors++;
        $display("FAIL mode%0d_empty_hold: got vld=%b imm=%h tag=%h want vld=0 imm=%h tag=%h",
                 i, out_valid, ExtImm, out_tag, v[i].imm, TAG_W'(i));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    exp_t        e[3];
    logic [23:0] ri[3];
    logic [2:0]  rs[3];
    for (int k = 0; k < 3; k++) begin
      ri[k] = 24'($urandom); rs[k] = 3'($urandom_range(0, 5));
      e[k]  = model(ri[k], rs[k], TAG_W'(k + 1));
    end
    out_ready = 1'b0; in_valid = 1'b1; Instr = ri[0]; ImmSrc = rs[0]; in_tag = 4'd1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_push1: got in_ready %b want 1", in_ready); end
    @(posedge clk); #1;
    Instr = ri[1]; ImmSrc = rs[1]; in_tag = 4'd2;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_push2: got in_ready %b want 1", in_ready); end
    @(posedge clk); #1;
    Instr = ri[2]; ImmSrc = rs[2]; in_tag = 4'd3;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got in_ready %b want 0", in_ready); end
    checks++;
    if ({ExtImm, out_tag, ext_err, rot_c} !== {e[0].imm, e[0].tag, e[0].err, e[0].rot}) begin
      errors++; $display("FAIL bp_head_stall: got imm=%h tag=%h want imm=%h tag=%h", ExtImm, out_tag, e[0].imm, e[0].tag);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if ({in_ready, out_valid} !== 2'b01) begin errors++; $display("FAIL bp_full_pop: got rdy/vld %b want 01", {in_ready, out_valid}); end
    checks++;
    if ({ExtImm, out_tag, ext_err, rot_c} !== {e[0].imm, e[0].tag, e[0].err, e[0].rot}) begin
      errors++; $display("FAIL bp_out1: got imm=%h tag=%h want imm=%h tag=%h", ExtImm, out_tag, e[0].imm, e[0].tag);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise: got in_ready %b want 1", in_ready); end
    checks++;
    if ({ExtImm, out_tag, ext_err, rot_c} !== {e[1].imm, e[1].tag, e[1].err, e[1].rot}) begin
      errors++; $display("FAIL bp_out2: got imm=%h tag=%h want imm=%h tag=%h", ExtImm, out_tag, e[1].imm, e[1].tag);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; Instr = 'x;
    @(negedge clk);
    checks++;
    if ({out_valid, ExtImm, out_tag, ext_err, rot_c} !== {1'b1, e[2].imm, e[2].tag, e[2].err, e[2].rot}) begin
      errors++; $display("FAIL bp_out3: got vld=%b imm=%h tag=%h want vld=1 imm=%h tag=%h", out_valid, ExtImm, out_tag, e[2].imm, e[2].tag);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got out_valid %b want 0", out_valid); end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [23:0] ri;
    logic [2:0]  rs;
    int          tagc = 0;
    sb.delete();
    out_ready = 1'b0; in_valid = 1'b1;
    ri = 24'($urandom); rs = 3'($urandom); Instr = ri; ImmSrc = rs; in_tag = TAG_W'(tagc);
    @(negedge clk);
    if (in_valid && in_ready) begin sb.push_back(model(ri, rs, TAG_W'(tagc))); tagc++; end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      ri = 24'($urandom); rs = 3'($urandom); Instr = ri; ImmSrc = rs; in_tag = TAG_W'(tagc); out_ready = 1'b1;
      @(negedge clk);
      checks++; if ({out_valid, in_ready} !== 2'b11) begin errors++; $display("FAIL b2b_flags%0d: got vld/rdy %b want 11", c, {out_valid, in_ready}); end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if ({ExtImm, out_tag, ext_err, rot_c} !== {e.imm, e.tag, e.err, e.rot}) begin
          errors++; $display("FAIL b2b_data%0d: got imm=%h tag=%h want imm=%h tag=%h", c, ExtImm, out_tag, e.imm, e.tag);
        end
      end
      if (in_valid && in_ready) begin sb.push_back(model(ri, rs, TAG_W'(tagc))); tagc++; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; Instr = 'x;
    @(negedge clk);
    checks++;
    if (sb.size() != 1) begin
      errors++; $display("FAIL b2b_depth: got model occupancy %0d want 1", sb.size());
    end else begin
      e = sb.pop_front();
      if ({out_valid, ExtImm, out_tag, ext_err, rot_c} !== {1'b1, e.imm, e.tag, e.err, e.rot}) begin
        errors++; $display("FAIL b2b_last: got vld=%b imm=%h tag=%h want vld=1 imm=%h tag=%h", out_valid, ExtImm, out_tag, e.imm, e.tag);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got out_valid %b want 0", out_valid); end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random_stream();
    exp_t        e;
    logic [23:0] ri;
    logic [2:0]  rs;
    int          tagc = 0;
    int          bound;
    sb.delete();
    for (int n = 0; n < 400; n++) begin
      ri = 24'($urandom); rs = 3'($urandom);
      in_valid = ($urandom_range(0, 2) != 0);
      if (in_valid) begin Instr = ri; ImmSrc = rs; in_tag = TAG_W'(tagc); end
      else begin Instr = 'x; ImmSrc = 'x; in_tag = 'x; end
      out_ready = (n < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== {sb.size() != 0, sb.size() != DEPTH}) begin
        errors++; $display("FAIL rs_flags%0d: got vld/rdy %b want %b", n, {out_valid, in_ready}, {sb.size() != 0, sb.size() != DEPTH});
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if ({ExtImm, out_tag, ext_err, rot_c} !== {e.imm, e.tag, e.err, e.rot}) begin
          errors++; $display("FAIL rs_data%0d: got imm=%h tag=%h err=%b rot=%b want imm=%h tag=%h err=%b rot=%b",
                             n, ExtImm, out_tag, ext_err, rot_c, e.imm, e.tag, e.err, e.rot);
        end
      end
      if (in_valid && in_ready) begin sb.push_back(model(ri, rs, TAG_W'(tagc))); tagc++; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; Instr = 'x; ImmSrc = 'x; in_tag = 'x; out_ready = 1'b1;
    bound = 0;
    while (sb.size() != 0 && bound < 20) begin
      @(negedge clk);
      if (out_valid) begin
        e = sb.pop_front();
        checks++;
        if ({ExtImm, out_tag, ext_err, rot_c} !== {e.imm, e.tag, e.err, e.rot}) begin
          errors++; $display("FAIL rs_drain: got imm=%h tag=%h want imm=%h tag=%h", ExtImm, out_tag, e.imm, e.tag);
        end
      end
      bound++;
      @(posedge clk); #1;
    end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rs_drain_timeout: got %0d entries left want 0", sb.size()); end
    out_ready = 1'b0;
    ImmSrc = '0; in_tag = '0;
  endtask

  task automatic test_async_reset();
    exp_t        e;
    logic [23:0] ri;
    logic [2:0]  rs;
    sb.delete();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      Instr = 24'($urandom); ImmSrc = 3'($urandom_range(0, 5)); in_tag = TAG_W'(k + 8);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; Instr = 'x;
    @(negedge clk);
    checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL ar_full: got vld/rdy %b want 10", {out_valid, in_ready}); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL ar_immediate: got vld/rdy %b want 01", {out_valid, in_ready}); end
    checks++; if ({ExtImm, out_tag, ext_err, rot_c} !== '0) begin errors++; $display("FAIL ar_outputs: got imm=%h tag=%h want 0", ExtImm, out_tag); end
    @(posedge clk); #3;
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_stale%0d: got out_valid %b want 0", c, out_valid); end
    end
    @(posedge clk); #1;
    ri = 24'($urandom); rs = 3'($urandom);
    in_valid = 1'b1; Instr = ri; ImmSrc = rs; in_tag = 4'd5;
    e = model(ri, rs, 4'd5);
    @(posedge clk); #1;
    in_valid = 1'b0; Instr = 'x;
    @(negedge clk);
    checks++;
    if ({out_valid, ExtImm, out_tag, ext_err, rot_c} !== {1'b1, e.imm, e.tag, e.err, e.rot}) begin
      errors++; $display("FAIL ar_resume: got vld=%b imm=%h tag=%h want vld=1 imm=%h tag=%h", out_valid, ExtImm, out_tag, e.imm, e.tag);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_back_to_back();
    test_random_stream();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
